// File: rtl/clock_meter_pkg.sv
// -----------------------------------------------------------------------------
// clock_meter_pkg
// Shared definitions for the clock period meter: the measurement FSM state
// encoding, the default counter width and the default nominal period,
// lock tolerance and lost-input timeout constants.
// -----------------------------------------------------------------------------
package clock_meter_pkg;

    // Default counter / period width in bits. It must hold TIMEOUT_DEF.
    localparam int CNT_W_DEF    = 22;
    // Nominal period in clk_in cycles (30 Hz at 100 MHz).
    localparam int EXPECTED_DEF = 3333334;
    // Allowed |period - EXPECTED| for lock.
    localparam int TOL_DEF      = 3334;
    // Edge-free cycle count that flags a lost input.
    localparam int TIMEOUT_DEF  = 4000000;

    // WAIT_EDGE: no reference edge yet. MEASURE: counting since the last edge.
    typedef enum logic [0:0] {
        WAIT_EDGE = 1'b0,
        MEASURE   = 1'b1
    } meter_state_e;

    // Lower lock bound, clamped at zero so a tolerance wider than the
    // nominal period cannot wrap around to a huge value.
    function automatic int lock_window_lo(input int expected, input int tol);
        if (expected > tol) begin
            return expected - tol;
        end else begin
            return 0;
        end
    endfunction

    // Upper lock bound.
    function automatic int lock_window_hi(input int expected, input int tol);
        return expected + tol;
    endfunction

endpackage : clock_meter_pkg

// File: rtl/sync_edge_detect.sv
// -----------------------------------------------------------------------------
// sync_edge_detect
// Brings a slow asynchronous input into the clk_in domain through a two-flop
// synchronizer plus one delay flop and flags its rising transitions.
//
// Ports
//   clk_in   : system clock, all logic on its rising edge
//   reset    : synchronous, active-high reset; clears every flop
//   async_in : asynchronous input level
//   level    : synchronized level (second synchronizer stage)
//   rise     : one-cycle pulse per rising transition (sync2 & ~sync3)
// -----------------------------------------------------------------------------
module sync_edge_detect (
    input  logic clk_in,
    input  logic reset,
    input  logic async_in,
    output logic level,
    output logic rise
);

    logic       sync1_q;
    logic       sync2_q;
    logic       sync3_q;
    // Tracks how many real samples have entered the pipeline since reset.
    logic [1:0] fill_q;
    // Set once a genuine low has been seen at sync2; until then a high level
    // is only the input being high at reset release and is not an edge.
    logic       armed_q;

    // Synchronizer, delay flop and arming state.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
            fill_q  <= 2'b00;
            armed_q <= 1'b0;
        end else begin
            sync1_q <= async_in;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            fill_q  <= {fill_q[0], 1'b1};
            // fill_q[1] means sync2 now holds a sample taken after reset.
            armed_q <= armed_q | (fill_q[1] & ~sync2_q);
        end
    end

    assign level = sync2_q;
    assign rise  = armed_q & sync2_q & ~sync3_q;

endmodule : sync_edge_detect

// File: rtl/clock_period_meter.sv
// -----------------------------------------------------------------------------
// clock_period_meter
// Measures the rising-to-rising period of a slow square wave in clk_in
// cycles, reports whether it lies within a tolerance of a nominal value and
// flags a lost input when no rising edge arrives for TIMEOUT cycles.
//
// Parameters
//   CNT_W    : counter / period width in bits
//   EXPECTED : nominal period in clk_in cycles
//   TOL      : allowed |period - EXPECTED| for lock
//   TIMEOUT  : edge-free cycle count that flags a lost input
//
// Ports
//   clk_in       : system clock, all logic on its rising edge
//   reset        : synchronous, active-high reset
//   sig_in       : slow square wave, asynchronous to clk_in
//   period       : last measured period in clk_in cycles
//   period_valid : one-cycle pulse when period updates
//   locked       : last period within tolerance and no timeout since
//   timeout      : sticky lost-input flag, cleared by the next rising edge
// -----------------------------------------------------------------------------
module clock_period_meter
    import clock_meter_pkg::*;
#(
    parameter int CNT_W    = CNT_W_DEF,
    parameter int EXPECTED = EXPECTED_DEF,
    parameter int TOL      = TOL_DEF,
    parameter int TIMEOUT  = TIMEOUT_DEF
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             locked,
    output logic             timeout
);

    // Lock window, one bit wider than the period so the bounds never wrap.
    localparam logic [CNT_W:0]   LOCK_LO = (CNT_W+1)'(lock_window_lo(EXPECTED, TOL));
    localparam logic [CNT_W:0]   LOCK_HI = (CNT_W+1)'(lock_window_hi(EXPECTED, TOL));
    // Counter value at which an edge-free cycle declares the input lost.
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

    meter_state_e     state_q;
    meter_state_e     state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] period_q;
    logic [CNT_W-1:0] period_d;
    logic             valid_q;
    logic             valid_d;
    logic             locked_q;
    logic             locked_d;
    logic             timeout_q;
    logic             timeout_d;

    logic             rise_s;
    logic             level_unused_s;
    logic [CNT_W:0]   meas_s;
    logic             in_window_s;

    sync_edge_detect u_sync_edge_detect (
        .clk_in   (clk_in),
        .reset    (reset),
        .async_in (sig_in),
        .level    (level_unused_s),
        .rise     (rise_s)
    );

    // The period ending on this cycle's edge: cycles since the previous edge
    // including the edge cycle itself, widened so the lock test cannot wrap.
    always_comb begin
        meas_s      = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
        in_window_s = (meas_s >= LOCK_LO) && (meas_s <= LOCK_HI);
    end

    // Next-state logic: an edge always wins over the timeout threshold.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        period_d  = period_q;
        valid_d   = 1'b0;
        locked_d  = locked_q;
        timeout_d = timeout_q;

        if (rise_s) begin
            timeout_d = 1'b0;
            cnt_d     = {CNT_W{1'b0}};
            state_d   = MEASURE;
            case (state_q)
                MEASURE: begin
                    period_d = meas_s[CNT_W-1:0];
                    valid_d  = 1'b1;
                    locked_d = in_window_s;
                end
                WAIT_EDGE: begin
                    // First edge only establishes the reference point.
                    period_d = period_q;
                end
                default: begin
                    state_d = WAIT_EDGE;
                end
            endcase
        end else if (cnt_q == CNT_MAX) begin
            // Input lost: saturate the counter and wait for a fresh reference.
            timeout_d = 1'b1;
            locked_d  = 1'b0;
            state_d   = WAIT_EDGE;
            cnt_d     = cnt_q;
        end else begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // State and output registers.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q   <= WAIT_EDGE;
            cnt_q     <= {CNT_W{1'b0}};
            period_q  <= {CNT_W{1'b0}};
            valid_q   <= 1'b0;
            locked_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            valid_q   <= valid_d;
            locked_q  <= locked_d;
            timeout_q <= timeout_d;
        end
    end

    assign period       = period_q;
    assign period_valid = valid_q;
    assign locked       = locked_q;
    assign timeout      = timeout_q;

endmodule : clock_period_meter

// File: tb/tb_clock_period_meter.sv
// -----------------------------------------------------------------------------
// tb_clock_period_meter
// Self-checking bench for clock_period_meter with EXPECTED=100, TOL=2,
// TIMEOUT=300, CNT_W=10. Every driven rising edge of sig_in is fed to a small
// reference model which pushes the expected period/lock result to a queue;
// a monitor pops and compares whenever period_valid pulses.
// -----------------------------------------------------------------------------
module tb_clock_period_meter;

    localparam int CNT_W    = 10;
    localparam int EXPECTED = 100;
    localparam int TOL      = 2;
    localparam int TIMEOUT  = 300;

    typedef struct {
        int per;
        bit lck;
        bit gap_chk;
    } exp_t;

    logic             clk_in;
    logic             reset;
    logic             sig_in;
    logic [CNT_W-1:0] period;
    logic             period_valid;
    logic             locked;
    logic             timeout;

    int   n_vec;
    int   n_err;
    int   tick;
    int   last_rise;
    bit   have_ref;
    bit   prev_pushed;
    exp_t exp_q[$];
    exp_t mon_e;
    int   mon_cyc;
    int   last_v;

    clock_period_meter #(
        .CNT_W    (CNT_W),
        .EXPECTED (EXPECTED),
        .TOL      (TOL),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk_in       (clk_in),
        .reset        (reset),
        .sig_in       (sig_in),
        .period       (period),
        .period_valid (period_valid),
        .locked       (locked),
        .timeout      (timeout)
    );

    // 100 MHz clock.
    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got no end of stimulus, required end before 200000 ns");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Advance n falling edges; inputs change and checks happen there.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_in);
            tick++;
        end
    endtask

    task automatic step_to(input int target);
        step(target - tick);
    endtask

    // Reference model: called at every driven rising edge of sig_in.
    task automatic model_rise();
        int gap;
        exp_t e;
        gap = tick - last_rise;
        if (have_ref && gap <= TIMEOUT) begin
            e.per     = gap;
            e.lck     = (gap >= EXPECTED - TOL) && (gap <= EXPECTED + TOL);
            e.gap_chk = prev_pushed;
            exp_q.push_back(e);
            prev_pushed = 1'b1;
        end else begin
            prev_pushed = 1'b0;
        end
        have_ref  = 1'b1;
        last_rise = tick;
    endtask

    // One rising edge, high for 'high' cycles; next rise is 'gap' cycles later.
    task automatic wave(input int gap, input int high);
        sig_in = 1'b1;
        model_rise();
        step(high);
        sig_in = 1'b0;
        step(gap - high);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        step(n);
        reset = 1'b0;
        have_ref    = 1'b0;
        prev_pushed = 1'b0;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_period"},  32'(period),       32'd0);
        chk({tag, "_valid"},   32'(period_valid), 32'd0);
        chk({tag, "_locked"},  32'(locked),       32'd0);
        chk({tag, "_timeout"}, 32'(timeout),      32'd0);
    endtask

    // Scoreboard monitor: every period_valid pulse must match the queue head,
    // and consecutive pulses must be spaced by the measured period.
    always @(negedge clk_in) begin
        mon_cyc++;
        if (period_valid) begin
            chk("valid_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                chk("period", 32'(period), 32'(mon_e.per));
                chk("locked", 32'(locked), 32'(mon_e.lck));
                if (mon_e.gap_chk) begin
                    chk("valid_spacing", 32'(mon_cyc - last_v), 32'(mon_e.per));
                end
            end
            last_v = mon_cyc;
        end
    end

    initial begin
        int t9;
        n_vec       = 0;
        n_err       = 0;
        tick        = 0;
        last_rise   = 0;
        have_ref    = 1'b0;
        prev_pushed = 1'b0;
        mon_cyc     = 0;
        last_v      = 0;
        reset       = 1'b1;
        sig_in      = 1'b0;

        // Reset state.
        step(1);
        do_reset(5);
        step(1);
        chk_idle("reset");
        step(9);

        // Nominal 100-cycle square wave: first edge is reference only.
        for (int i = 0; i < 5; i++) begin
            wave(100, 50);
        end

        // Off-nominal periods 102, 103, 98 measured at the following edges.
        wave(102, 50);
        wave(103, 51);
        wave(98, 49);

        // Last edge, then input held low until timeout.
        sig_in = 1'b1;
        model_rise();
        t9 = tick;
        step(40);
        sig_in = 1'b0;
        step_to(t9 + 302);
        chk("pre_timeout_flag",   32'(timeout), 32'd0);
        chk("pre_timeout_locked", 32'(locked),  32'd1);
        step(1);
        chk("timeout_flag",   32'(timeout), 32'd1);
        chk("timeout_locked", 32'(locked),  32'd0);
        chk("timeout_period", 32'(period),  32'd98);
        step(20);

        // Edge after timeout clears the flag and produces no period_valid.
        sig_in = 1'b1;
        model_rise();
        step(5);
        chk("timeout_cleared", 32'(timeout), 32'd0);
        chk("relock_locked",   32'(locked),  32'd0);
        chk("held_period",     32'(period),  32'd98);
        step(45);
        sig_in = 1'b0;
        step(50);

        // 100 again, then an edge exactly on the timeout threshold (300).
        wave(300, 60);
        wave(50, 20);
        chk("threshold_timeout", 32'(timeout), 32'd0);
        chk("threshold_period",  32'(period),  32'd300);
        wave(80, 40);

        // Reset 50 cycles into a period with sig_in still high at release.
        sig_in = 1'b1;
        model_rise();
        step(50);
        do_reset(2);
        step(3);
        chk_idle("midreset");
        step(10);
        sig_in = 1'b0;
        step(40);
        wave(100, 50);
        chk("after_ref_period", 32'(period), 32'd0);
        chk("after_ref_locked", 32'(locked), 32'd0);

        // One-cycle glitches, each one edge.
        wave(80, 1);
        wave(99, 1);
        wave(50, 25);
        step(10);

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_clock_period_meter
